// File: rtl/sram_request_scheduler.sv
// sram_request_scheduler
//   Round-robin arbiter between NUM_REQ memory requesters and the single SRAM
//   sequencer port. Each requester owns one holding slot; a granted request
//   is issued downstream with a one-cycle start pulse. The scheduler then
//   waits for the sequencer's done pulse and returns a one-cycle completion
//   pulse carrying the read data.
//
//   Ports
//     clk, reset              clock, asynchronous active-high reset
//     req_valid/write/size    per-requester request (size 0 = no memory access)
//     req_addr/req_wdata      per-requester address/data, requester i at [i*W +: W]
//     req_ready               slot i free (combinational from the pending flag)
//     rsp_valid/rsp_rdata     completion pulse for the granted requester + read data
//     mem_start               one-cycle issue pulse to the sequencer
//     mem_write/size/addr/wdata  issued command, held until the next grant
//     mem_done/mem_rdata      sequencer completion and read data
//     grant_id                requester currently (or most recently) granted
module sram_request_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_write,
  input  logic [2*NUM_REQ-1:0]       req_size,
  input  logic [ADDR_W*NUM_REQ-1:0]  req_addr,
  input  logic [DATA_W*NUM_REQ-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       mem_start,
  output logic                       mem_write,
  output logic [1:0]                 mem_size,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic                       mem_done,
  input  logic [DATA_W-1:0]          mem_rdata,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t             state;
  state_t             state_nxt;

  logic [NUM_REQ-1:0] pending;
  logic [NUM_REQ-1:0] accept;
  logic               slot_write [NUM_REQ];
  logic [1:0]         slot_size  [NUM_REQ];
  logic [ADDR_W-1:0]  slot_addr  [NUM_REQ];
  logic [DATA_W-1:0]  slot_wdata [NUM_REQ];

  logic [ID_W-1:0]    last_grant;
  logic [ID_W-1:0]    scan_id;
  logic [ID_W-1:0]    pick_id;
  logic               pick_found;
  logic               grant_now;

  assign req_ready = ~pending;
  assign accept    = req_valid & ~pending;
  assign mem_start = (state == S_ISSUE);
  assign grant_now = (state == S_IDLE) && pick_found;

  always_comb begin
    rsp_valid = '0;
    if (state == S_RESP) rsp_valid[grant_id] = 1'b1;
  end

  // Scan downward so the last hit is the first pending requester found
  // when walking upward from last_grant+1 with wrap.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    scan_id    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      scan_id = ID_W'((int'(last_grant) + k) % NUM_REQ);
      if (pending[scan_id]) begin
        pick_found = 1'b1;
        pick_id    = scan_id;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (pick_found) state_nxt = (slot_size[pick_id] != 2'd0) ? S_ISSUE : S_RESP;
      S_ISSUE: state_nxt = S_WAIT;                    // mem_done here is ignored
      S_WAIT:  if (mem_done) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // A slot is freed by its own completion pulse; it cannot be re-accepted
  // in the same cycle because req_ready is still low then.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending <= '0;
    else       pending <= (pending & ~rsp_valid) | accept;
  end

  // Slot contents are frozen while pending; only the accept edge writes them.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (accept[i]) begin
        slot_write[i] <= req_write[i];
        slot_size[i]  <= req_size[2*i +: 2];
        slot_addr[i]  <= req_addr[i*ADDR_W +: ADDR_W];
        slot_wdata[i] <= req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Grant / issue registers: loaded on the grant decision, held through WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_id   <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
      mem_write  <= 1'b0;
      mem_size   <= 2'd0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rsp_rdata  <= '0;
    end else begin
      if (grant_now) begin
        grant_id   <= pick_id;
        last_grant <= pick_id;
        mem_write  <= slot_write[pick_id];
        mem_size   <= slot_size[pick_id];
        mem_addr   <= slot_addr[pick_id];
        mem_wdata  <= slot_wdata[pick_id];
        if (slot_size[pick_id] == 2'd0) rsp_rdata <= '0;
      end
      if ((state == S_WAIT) && mem_done) rsp_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_sram_request_scheduler.sv
module tb_sram_request_scheduler;

  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic             clk;
  logic             reset;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_write;
  logic [2*NR-1:0]  req_size;
  logic [AW*NR-1:0] req_addr;
  logic [DW*NR-1:0] req_wdata;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    rsp_valid;
  logic [DW-1:0]    rsp_rdata;
  logic             mem_start;
  logic             mem_write;
  logic [1:0]       mem_size;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_wdata;
  logic             mem_done;
  logic [DW-1:0]    mem_rdata;
  logic [1:0]       grant_id;

  sram_request_scheduler #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_size  (req_size),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .mem_start (mem_start),
    .mem_write (mem_write),
    .mem_size  (mem_size),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_done  (mem_done),
    .mem_rdata (mem_rdata),
    .grant_id  (grant_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_err    = 0;
  int w        = 0;   // index of the clock window currently observed

  // Reference model: pending set, slot copies, round-robin pointer and the
  // window numbers at which the current transaction issues (m_g) and responds (m_r).
  logic [NR-1:0] m_pend;
  logic          m_write [NR];
  logic [1:0]    m_size  [NR];
  logic [AW-1:0] m_addr  [NR];
  logic [DW-1:0] m_wdata [NR];
  int            m_last, m_cur, m_gid, m_g, m_r;
  bit            m_busy;
  logic [DW-1:0] m_rexp;

  // Sequencer emulation knobs.
  int            cfg_delay;
  bit            cfg_spur, rand_spur, cfg_fixed, force_done;
  logic [DW-1:0] cfg_data;
  int            done_at;
  logic [DW-1:0] done_val;

  // Observations for directed checks.
  int            n_start, n_rsp;
  logic [31:0]   gl;
  logic [DW-1:0] obs_rsp_data;
  logic [AW-1:0] obs_start_addr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h (window %0d)", tag, obs, exp, w);
    end
  endtask

  function automatic int rr_pick(input logic [NR-1:0] p, input int last);
    for (int k = 1; k <= NR; k++)
      if (p[(last + k) % NR]) return (last + k) % NR;
    return -1;
  endfunction

  task automatic model_reset();
    m_pend  = '0;
    m_busy  = 1'b0;
    m_last  = NR - 1;
    m_gid   = 0;
    m_cur   = 0;
    m_g     = -1;
    m_r     = -1;
    done_at = -1;
  endtask

  task automatic check_window();
    logic [NR-1:0] exp_rdy;
    logic [NR-1:0] exp_rsp;
    bit            exp_start;
    exp_rdy   = ~m_pend;
    exp_rsp   = '0;
    if (m_busy && w == m_r) exp_rsp[m_cur] = 1'b1;
    exp_start = m_busy && (w == m_g) && (m_size[m_cur] != 2'd0);
    chk("req_ready", req_ready, exp_rdy);
    chk("rsp_valid", rsp_valid, exp_rsp);
    chk("mem_start", mem_start, exp_start);
    chk("grant_id",  grant_id,  64'(m_gid));
    if (m_busy && m_size[m_cur] != 2'd0) begin
      chk("mem_addr",  mem_addr,  m_addr[m_cur]);
      chk("mem_write", mem_write, m_write[m_cur]);
      chk("mem_size",  mem_size,  m_size[m_cur]);
      chk("mem_wdata", mem_wdata, m_wdata[m_cur]);
    end
    if (m_busy && w == m_r) chk("rsp_rdata", rsp_rdata, m_rexp);
  endtask

  // One clock window: check outputs, drive the sequencer, advance the model,
  // then move to the next falling edge.
  task automatic tick();
    logic [NR-1:0] rdy_old;
    check_window();
    if (mem_start === 1'b1) begin
      n_start++;
      gl = {gl[27:0], 2'b00, grant_id};
      obs_start_addr = mem_addr;
    end
    if (rsp_valid !== '0) begin
      n_rsp++;
      obs_rsp_data = rsp_rdata;
    end

    mem_done  = 1'b0;
    mem_rdata = '0;
    if (m_busy && w == m_g && m_size[m_cur] != 2'd0) begin
      done_at  = w + ((cfg_delay > 0) ? cfg_delay : int'($urandom_range(1, 4)));
      done_val = cfg_fixed ? cfg_data : $urandom;
      if (cfg_spur || (rand_spur && $urandom_range(0, 3) == 0)) begin
        mem_done  = 1'b1;
        mem_rdata = $urandom;
      end
    end
    if (m_busy && m_r < 0 && w == done_at) begin
      mem_done  = 1'b1;
      mem_rdata = done_val;
    end
    if (force_done) begin
      mem_done  = 1'b1;
      mem_rdata = $urandom;
    end

    rdy_old = ~m_pend;
    if (m_busy) begin
      if (w == m_r) begin
        m_pend[m_cur] = 1'b0;
        m_busy        = 1'b0;
      end else if (m_r < 0 && mem_done && w > m_g) begin
        m_r    = w + 1;
        m_rexp = mem_rdata;
      end
    end else if (m_pend != '0) begin
      m_cur  = rr_pick(m_pend, m_last);
      m_last = m_cur;
      m_gid  = m_cur;
      m_busy = 1'b1;
      m_g    = w + 1;
      if (m_size[m_cur] == 2'd0) begin
        m_r    = w + 1;
        m_rexp = '0;
      end else begin
        m_r = -1;
      end
    end
    for (int i = 0; i < NR; i++) begin
      if (req_valid[i] && rdy_old[i]) begin
        m_pend[i]  = 1'b1;
        m_write[i] = req_write[i];
        m_size[i]  = req_size[2*i +: 2];
        m_addr[i]  = req_addr[i*AW +: AW];
        m_wdata[i] = req_wdata[i*DW +: DW];
      end
    end

    @(posedge clk);
    @(negedge clk);
    w++;
  endtask

  task automatic set_req(input int i, input bit wr, input logic [1:0] sz,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]        = 1'b1;
    req_write[i]        = wr;
    req_size[2*i +: 2]  = sz;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic randomize_reqs();
    for (int i = 0; i < NR; i++) begin
      req_valid[i]          = ($urandom_range(0, 2) == 0);
      req_write[i]          = 1'($urandom_range(0, 1));
      req_size[2*i +: 2]    = 2'($urandom_range(0, 3));
      req_addr[i*AW +: AW]  = $urandom;
      req_wdata[i*DW +: DW] = $urandom;
    end
  endtask

  task automatic drain();
    int budget;
    budget    = 200;
    req_valid = '0;
    while ((m_busy || m_pend != '0) && budget > 0) begin
      tick();
      budget--;
    end
    chk("drain_budget", (budget > 0), 1);
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_req_ready", req_ready, 4'hF);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_mem_start", mem_start, 0);
    chk("rst_grant_id",  grant_id,  0);
    chk("rst_mem_addr",  mem_addr,  0);
    chk("rst_mem_size",  mem_size,  0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    @(posedge clk);
    @(negedge clk);
    reset    = 1'b0;
    mem_done = 1'b0;
    model_reset();
    w++;
  endtask

  initial begin
    int base_s, base_r, budget;
    reset = 1'b1;
    req_valid = '0; req_write = '0; req_size = '0; req_addr = '0; req_wdata = '0;
    mem_done = 1'b0; mem_rdata = '0;
    cfg_delay = 0; cfg_spur = 0; rand_spur = 0; cfg_fixed = 0; force_done = 0;
    cfg_data = '0; done_val = '0; m_rexp = '0;
    n_start = 0; n_rsp = 0; gl = '1; obs_rsp_data = '0; obs_start_addr = '0;
    for (int i = 0; i < NR; i++) begin
      m_write[i] = 1'b0; m_size[i] = 2'd0; m_addr[i] = '0; m_wdata[i] = '0;
    end
    model_reset();
    @(negedge clk);
    do_reset();

    // Single read from requester 0, done three cycles after start.
    cfg_delay = 3; cfg_fixed = 1; cfg_data = 32'hDEADBEEF;
    base_s = n_start; base_r = n_rsp;
    set_req(0, 1'b0, 2'd3, 32'h0000_0100, 32'h0);
    tick();
    drain();
    chk("t1_start_count", n_start - base_s, 1);
    chk("t1_start_addr",  obs_start_addr, 32'h0000_0100);
    chk("t1_rsp_count",   n_rsp - base_r, 1);
    chk("t1_rsp_rdata",   obs_rsp_data, 32'hDEADBEEF);
    cfg_fixed = 0;

    // All four requesters at once after reset, then 0 and 2 again.
    do_reset();
    cfg_delay = 0;
    gl = '1;
    for (int i = 0; i < NR; i++) set_req(i, 1'(i & 1), 2'd3, $urandom, $urandom);
    tick();
    drain();
    chk("t2_order_a", gl, 32'hFFFF_0123);
    set_req(0, 1'b1, 2'd1, $urandom, $urandom);
    set_req(2, 1'b0, 2'd2, $urandom, $urandom);
    tick();
    drain();
    chk("t2_order_b", gl, 32'hFF01_2302);

    // Requesters 1 and 2 held valid, done one cycle after start.
    cfg_delay = 1;
    gl = '1;
    base_s = n_start;
    set_req(1, 1'b0, 2'd1, 32'h0000_1001, 32'h0);
    set_req(2, 1'b0, 2'd2, 32'h0000_2002, 32'h0);
    budget = 80;
    while ((n_start - base_s) < 4 && budget > 0) begin
      tick();
      budget--;
    end
    chk("t3_budget", (budget > 0), 1);
    chk("t3_alternate", gl, 32'hFFFF_1212);
    drain();

    // Size-0 write from requester 3: no memory access, zero read data.
    cfg_delay = 0;
    base_s = n_start; base_r = n_rsp;
    obs_rsp_data = '1;
    set_req(3, 1'b1, 2'd0, $urandom, $urandom);
    tick();
    drain();
    chk("t4_no_start",   n_start - base_s, 0);
    chk("t4_rsp_count",  n_rsp - base_r, 1);
    chk("t4_rsp_rdata",  obs_rsp_data, 0);
    chk("t4_ready_back", req_ready, 4'hF);

    // mem_done during the issue cycle must be ignored.
    cfg_spur = 1; cfg_delay = 3;
    base_r = n_rsp;
    set_req(1, 1'b0, 2'd2, $urandom, $urandom);
    tick();
    drain();
    chk("t5_rsp_count", n_rsp - base_r, 1);
    cfg_spur = 0;

    // Reset while waiting, then a stray mem_done after release.
    cfg_delay = 8;
    base_s = n_start;
    set_req(0, 1'b0, 2'd3, $urandom, $urandom);
    tick();
    req_valid = '0;
    budget = 20;
    while (!(m_busy && w == m_g + 2) && budget > 0) begin
      tick();
      budget--;
    end
    chk("t6_budget", (budget > 0), 1);
    do_reset();
    base_r = n_rsp;
    force_done = 1;
    tick();
    force_done = 0;
    for (int k = 0; k < 4; k++) tick();
    chk("t6_no_rsp",     n_rsp - base_r, 0);
    chk("t6_one_start",  n_start - base_s, 1);
    chk("t6_ready_all",  req_ready, 4'hF);

    // Randomized traffic against the model.
    cfg_delay = 0; rand_spur = 1;
    for (int k = 0; k < 400; k++) begin
      randomize_reqs();
      tick();
    end
    drain();
    chk("rand_activity", (n_start > 20), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
